// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one-at-a-time word reads and buffers returns.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            r_state, w_state_next;
  logic              r_drop, w_drop_next;
  logic [31:0]       r_fetch_pc, w_fetch_pc_next;
  logic [31:0]       r_req_pc;
  logic [31:0]       r_buf_data [BUF_DEPTH];
  logic [31:0]       r_buf_pc   [BUF_DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count, w_count_next;
  logic              w_push, w_pop, w_accept;

  assign imem_req_valid = (r_state == StReq) && !r_drop;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = (r_count != '0);
  assign instr_data     = r_buf_data[r_rptr];
  assign instr_pc       = r_buf_pc[r_rptr];

  always_comb begin
    w_push          = (r_state == StWait) && imem_rsp_valid && !r_drop;
    w_pop           = instr_valid && instr_ready;
    w_accept        = imem_req_valid && imem_req_ready;
    w_count_next    = r_count + CntW'(w_push) - CntW'(w_pop);
    w_state_next    = r_state;
    w_drop_next     = r_drop && !imem_rsp_valid;
    w_fetch_pc_next = r_fetch_pc;

    unique case (r_state)
      StIdle: if (r_count != Full) w_state_next = StReq;
      StReq: begin
        if (w_accept) begin
          w_state_next    = StWait;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
        end
      end
      StWait: begin
        if (imem_rsp_valid) w_state_next = (w_count_next != Full) ? StReq : StIdle;
      end
      default: w_state_next = StIdle;
    endcase

    // A redirect leaves any in-flight or just-accepted request owed a response we must discard.
    if (redirect_valid) begin
      w_state_next    = StReq;
      w_fetch_pc_next = redirect_pc & ~32'h3;
      w_drop_next     = ((r_state == StWait) && !imem_rsp_valid) || w_accept ||
                        (r_drop && !imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_drop     <= 1'b0;
      r_fetch_pc <= RESET_PC & ~32'h3;
      r_req_pc   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_drop     <= w_drop_next;
      r_fetch_pc <= w_fetch_pc_next;
      if (w_accept) r_req_pc <= r_fetch_pc;
      if (redirect_valid) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_buf_data[r_wptr] <= imem_rsp_data;
          r_buf_pc[r_wptr]   <= r_req_pc;
          r_wptr             <= r_wptr + 1'b1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        r_count <= w_count_next;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (w_push) fetch_count <= fetch_count + 32'd1;
      if (!instr_valid && !redirect_valid) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
